// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU op encodings,
// control-bundle layout and a simulation-safe control sanitiser.
package id_ex_pipe_reg_pkg;

  // Default datapath and register-specifier widths for the MIPS core
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_REG_AW = 5;
  localparam int IMM_W          = 16;

  // ALU op encodings produced by the main control unit
  localparam logic [1:0] ALU_OP_MEM   = 2'b00;
  localparam logic [1:0] ALU_OP_BR    = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;

  // Control bundle width and bit positions inside the flat bundle
  localparam int CTRL_W          = 9;
  localparam int CTRL_REG_DST    = 8;
  localparam int CTRL_BRANCH     = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_OP_HI  = 4;
  localparam int CTRL_ALU_OP_LO  = 3;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_ALU_SRC    = 1;
  localparam int CTRL_REG_WRITE  = 0;

  // Structured view of the same bundle; field order matches the bit indices
  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  // The control unit leaves don't-care bits as X for stores and branches.
  // A case-equality guard turns any X/Z bit into 0 in simulation so that no
  // unknown ever reaches EX; synthesis sees a plain pass-through.
  function automatic logic [CTRL_W-1:0] sanitize_ctrl(input logic [CTRL_W-1:0] raw);
    logic [CTRL_W-1:0] clean;
    clean = '0;
    for (int i = 0; i < CTRL_W; i++) begin
      clean[i] = (raw[i] === 1'b1);
    end
    return clean;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_hazard_detect.sv
// Load-use hazard detector: flags when the instruction in decode needs a
// register that the load currently in EX has not yet fetched from memory.
module hazard_detect
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int REG_AW = DEFAULT_REG_AW
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_alu_src,
  input  logic              id_mem_write,
  output logic              haz
);

  logic w_load_in_ex;
  logic w_rs_match;
  logic w_rt_match;
  logic w_rt_consumed;

  // A real load in EX writing a non-zero register; $0 never carries a dependency
  assign w_load_in_ex = ex_valid & ex_mem_read & (ex_rt != '0);

  // rs is always read as an ALU operand
  assign w_rs_match = (ex_rt == id_rs);

  // rt matters when it feeds the ALU (no immediate) or is the store data
  assign w_rt_match    = (ex_rt == id_rt);
  assign w_rt_consumed = ~id_alu_src | id_mem_write;

  // Combine into the single-cycle hazard flag
  assign haz = w_load_in_ex & (w_rs_match | (w_rt_match & w_rt_consumed));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: carries the decode bundle into EX one cycle later,
// inserting bubbles for flushes, load-use hazards and empty decode slots.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REG_AW = DEFAULT_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_reg_dst,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_to_reg,
  input  logic [1:0]        id_alu_op,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_to_reg,
  output logic [1:0]        ex_alu_op,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              stall_if_id
);

  // Pipeline state
  logic              r_valid;
  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_pc_plus4;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;

  // Decode-side combinational values
  logic [CTRL_W-1:0] w_id_ctrl_raw;
  ctrl_t             w_id_ctrl;
  logic [DATA_W-1:0] w_imm_ext;
  logic              w_haz;
  logic              w_bubble;

  // Flatten the control-unit outputs into the bundle layout
  assign w_id_ctrl_raw[CTRL_REG_DST]    = id_reg_dst;
  assign w_id_ctrl_raw[CTRL_BRANCH]     = id_branch;
  assign w_id_ctrl_raw[CTRL_MEM_READ]   = id_mem_read;
  assign w_id_ctrl_raw[CTRL_MEM_TO_REG] = id_mem_to_reg;
  assign w_id_ctrl_raw[CTRL_ALU_OP_HI]  = id_alu_op[1];
  assign w_id_ctrl_raw[CTRL_ALU_OP_LO]  = id_alu_op[0];
  assign w_id_ctrl_raw[CTRL_MEM_WRITE]  = id_mem_write;
  assign w_id_ctrl_raw[CTRL_ALU_SRC]    = id_alu_src;
  assign w_id_ctrl_raw[CTRL_REG_WRITE]  = id_reg_write;

  // Strip X/Z don't-cares before they can be captured
  assign w_id_ctrl = ctrl_t'(sanitize_ctrl(w_id_ctrl_raw));

  // Sign-extend the 16-bit immediate to the datapath width
  assign w_imm_ext = {{(DATA_W-16){id_imm[15]}}, id_imm};

  // Load-use hazard against the instruction currently held in EX
  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .ex_valid     (r_valid),
    .ex_mem_read  (r_ctrl.mem_read),
    .ex_rt        (r_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_alu_src   (id_alu_src),
    .id_mem_write (id_mem_write),
    .haz          (w_haz)
  );

  // A bubble goes into EX when the decode slot is empty or must wait on a load
  assign w_bubble = w_haz | ~id_valid;

  // Freeze IF/ID only for a real decode instruction that survives this edge;
  // a taken branch kills the slot, so there is nothing to wait for
  assign stall_if_id = w_haz & id_valid & ~flush & ~rst;

  // Valid and control bits: reset, freeze, kill, bubble or load, in that order
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (hold) begin
      r_valid <= r_valid;
      r_ctrl  <= r_ctrl;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (w_bubble) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid <= 1'b1;
      r_ctrl  <= w_id_ctrl;
    end
  end

  // Data and specifiers follow decode on every unfrozen edge; in a bubble they
  // are harmless because every side-effecting control bit is cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_plus4 <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
    end else if (!hold) begin
      r_pc_plus4 <= id_pc_plus4;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= w_imm_ext;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
    end
  end

  // Present the registered bundle to EX
  assign ex_valid      = r_valid;
  assign ex_reg_dst    = r_ctrl.reg_dst;
  assign ex_branch     = r_ctrl.branch;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_pc_plus4   = r_pc_plus4;
  assign ex_rs_data    = r_rs_data;
  assign ex_rt_data    = r_rt_data;
  assign ex_imm        = r_imm;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;

endmodule
